// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in / parallel-out frame receiver.
// Contents:
//   state_t        - frame sequencer states (IDLE, DATA, STOP)
//   DEFAULT_WIDTH  - default number of data bits per frame
package sipo_ctrl_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } state_t;

endpackage : sipo_ctrl_pkg

// File: rtl/sipo_frame_ctrl_if.sv
// Consumer-side handshake bundle of the frame receiver.
// Signals:
//   Pout  - parallel word presented to the consumer
//   valid - Pout holds an unconsumed word
//   ready - consumer accepts Pout
// Modports:
//   master - the receiver (drives Pout/valid, samples ready)
//   slave  - the consumer (samples Pout/valid, drives ready)
interface sipo_frame_ctrl_if
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] Pout;
   logic             valid;
   logic             ready;

   modport master (output Pout, output valid, input ready);
   modport slave  (input Pout, input valid, output ready);

endinterface : sipo_frame_ctrl_if

// File: rtl/sipo_shift.sv
// Serial-to-parallel shift register, LSB first.
// Each shift_en cycle moves Sin into the MSB and shifts everything toward
// bit 0, so after WIDTH shifts the first bit received sits in q[0].
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears q)
//   shift_en  - shift one bit in this cycle
//   Sin       - serial data bit
//   q         - shift register contents
module sipo_shift
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             shift_en,
   input  logic             Sin,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_reg <= '0;
      end else if (shift_en) begin
         q_reg <= {Sin, q_reg[WIDTH-1:1]};
      end
   end

   assign q = q_reg;

endmodule : sipo_shift

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: start bit (0), WIDTH data bits LSB first, stop bit (1).
// Bits are sampled only on cycles with en=1. A good frame is committed to
// Pout/valid one cycle after the stop-bit sample; a bad stop bit pulses
// frame_err and drops the word; a commit that finds the previous word still
// unconsumed drops the new word and pulses overrun.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   en         - bit strobe
//   Sin        - serial line (idles at 1)
//   ready      - consumer accepts Pout (ignored while valid=0)
//   Pout       - received word
//   valid      - Pout holds an unconsumed word
//   busy       - a frame is in progress
//   frame_err  - one-cycle pulse, stop bit was 0
//   overrun    - one-cycle pulse, a committed word was dropped
module sipo_frame_ctrl
   import sipo_ctrl_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             Sin,
   input  logic             ready,
   output logic [WIDTH-1:0] Pout,
   output logic             valid,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun
);

   localparam int             CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] pout_reg;
   logic             valid_reg;
   logic             frame_err_reg;
   logic             overrun_reg;
   logic [WIDTH-1:0] shift_q;
   logic             shift_en;

   // Data bits are shifted in only while collecting them.
   assign shift_en = en && (state_reg == DATA);

   sipo_shift #(
      .WIDTH (WIDTH)
   ) u_shift (
      .clk      (clk),
      .rst      (rst),
      .shift_en (shift_en),
      .Sin      (Sin),
      .q        (shift_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         pout_reg      <= '0;
         valid_reg     <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;

         // Consumption; a same-cycle commit below overrides this.
         if (valid_reg && ready) begin
            valid_reg <= 1'b0;
         end

         if (en) begin
            case (state_reg)
               IDLE: begin
                  if (!Sin) begin
                     state_reg <= DATA;
                     cnt_reg   <= '0;
                  end
               end
               DATA: begin
                  // Counter saturates at the last bit index instead of wrapping.
                  if (cnt_reg == LAST) begin
                     state_reg <= STOP;
                  end else begin
                     cnt_reg <= cnt_reg + 1'b1;
                  end
               end
               STOP: begin
                  state_reg <= IDLE;
                  if (Sin) begin
                     // Room exists if nothing is held or the held word leaves now.
                     if (!valid_reg || ready) begin
                        pout_reg  <= shift_q;
                        valid_reg <= 1'b1;
                     end else begin
                        overrun_reg <= 1'b1;
                     end
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

   assign Pout      = pout_reg;
   assign valid     = valid_reg;
   assign busy      = (state_reg != IDLE);
   assign frame_err = frame_err_reg;
   assign overrun   = overrun_reg;

endmodule : sipo_frame_ctrl

// File: tb/tb_sipo_frame_ctrl.sv
module tb_sipo_frame_ctrl;

   localparam int W = 4;

   logic clk = 1'b0;
   logic rst;
   logic en;
   logic Sin;
   logic busy;
   logic frame_err;
   logic overrun;

   sipo_frame_ctrl_if #(.WIDTH(W)) bus ();

   sipo_frame_ctrl #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .Sin       (Sin),
      .ready     (bus.ready),
      .Pout      (bus.Pout),
      .valid     (bus.valid),
      .busy      (busy),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Frame-level reference: collects the bits following a start bit in a
   // queue; when WIDTH+1 bits are in, the last one is the stop bit and the
   // others form the word (first bit = weight 1).
   bit         m_in_frame;
   int         m_bits[$];
   logic [W-1:0] m_pout;
   bit         m_valid;
   bit         m_ferr;
   bit         m_ovr;

   task automatic model_step(input bit r, input bit e, input bit s, input bit rdy);
      bit old_valid;
      int word;
      if (r) begin
         m_in_frame = 0;
         m_bits.delete();
         m_pout  = '0;
         m_valid = 0;
         m_ferr  = 0;
         m_ovr   = 0;
         return;
      end
      m_ferr    = 0;
      m_ovr     = 0;
      old_valid = m_valid;
      if (old_valid && rdy) m_valid = 0;
      if (e) begin
         if (!m_in_frame) begin
            if (!s) begin
               m_in_frame = 1;
               m_bits.delete();
            end
         end else begin
            m_bits.push_back(int'(s));
            if (m_bits.size() == W + 1) begin
               m_in_frame = 0;
               if (m_bits[W] == 1) begin
                  word = 0;
                  for (int i = 0; i < W; i++) word += m_bits[i] * (1 << i);
                  if (!old_valid || rdy) begin
                     m_pout  = W'(word);
                     m_valid = 1;
                  end else begin
                     m_ovr = 1;
                  end
               end else begin
                  m_ferr = 1;
               end
            end
         end
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic cycle(input bit r, input bit e, input bit s, input bit rdy);
      rst       = r;
      en        = e;
      Sin       = s;
      bus.ready = rdy;
      @(posedge clk);
      model_step(r, e, s, rdy);
      #1;
      check("pout",      32'(bus.Pout),  32'(m_pout));
      check("valid",     32'(bus.valid), 32'(m_valid));
      check("busy",      32'(busy),      32'(m_in_frame));
      check("frame_err", 32'(frame_err), 32'(m_ferr));
      check("overrun",   32'(overrun),   32'(m_ovr));
      @(negedge clk);
   endtask

   // Start bit, W data bits LSB first, stop bit; ready only on the stop cycle.
   task automatic send_frame(input logic [W-1:0] w, input bit stopb, input bit rdy_stop);
      logic [W-1:0] wv;
      wv = w;
      cycle(0, 1, 0, 0);
      for (int i = 0; i < W; i++) cycle(0, 1, wv[i], 0);
      cycle(0, 1, stopb, rdy_stop);
   endtask

   task automatic do_reset();
      cycle(1, 1, 0, 1);
      check("rst_pout",  32'(bus.Pout),  32'(0));
      check("rst_valid", 32'(bus.valid), 32'(0));
      check("rst_busy",  32'(busy),      32'(0));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; Sin = 1'b1; bus.ready = 1'b0;
      @(negedge clk);

      // Scenario 1: 0,1,0,1,1,1 -> 4'hD, then consume.
      do_reset();
      send_frame(4'hD, 1, 0);
      check("s1_pout",  32'(bus.Pout),  32'hD);
      check("s1_valid", 32'(bus.valid), 32'd1);
      cycle(0, 1, 1, 1);
      check("s1_consumed", 32'(bus.valid), 32'd0);

      // Scenario 2: bad stop bit.
      do_reset();
      send_frame(4'hF, 0, 0);
      check("s2_ferr",  32'(frame_err), 32'd1);
      check("s2_valid", 32'(bus.valid), 32'd0);
      check("s2_busy",  32'(busy),      32'd0);
      cycle(0, 1, 1, 0);
      check("s2_ferr_pulse", 32'(frame_err), 32'd0);

      // Scenario 3: back-to-back frames, no consumer -> overrun.
      do_reset();
      send_frame(4'hD, 1, 0);
      send_frame(4'h3, 1, 0);
      check("s3_ovr",   32'(overrun),   32'd1);
      check("s3_pout",  32'(bus.Pout),  32'hD);
      check("s3_valid", 32'(bus.valid), 32'd1);
      cycle(0, 1, 1, 0);
      check("s3_ovr_pulse", 32'(overrun), 32'd0);

      // Scenario 4: ready during the second commit -> new word loads.
      do_reset();
      send_frame(4'hD, 1, 0);
      send_frame(4'h3, 1, 1);
      check("s4_ovr",   32'(overrun),   32'd0);
      check("s4_pout",  32'(bus.Pout),  32'h3);
      check("s4_valid", 32'(bus.valid), 32'd1);

      // Scenario 5: reset after the second data bit, then 4'hA.
      do_reset();
      send_frame(4'h5, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(0, 1, 1, 0);
      cycle(0, 1, 0, 0);
      cycle(1, 1, 1, 0);
      check("s5_busy",  32'(busy),      32'd0);
      check("s5_valid", 32'(bus.valid), 32'd0);
      check("s5_pout",  32'(bus.Pout),  32'd0);
      send_frame(4'hA, 1, 0);
      check("s5_pout_a", 32'(bus.Pout), 32'hA);

      // Scenario 6: en every other cycle, Sin scrambled on en=0 cycles.
      do_reset();
      begin
         bit seq[6];
         seq = '{0, 1, 0, 1, 1, 1};
         for (int i = 0; i < 6; i++) begin
            cycle(0, 1, seq[i], 0);
            cycle(0, 0, 1'($urandom), 0);
         end
      end
      check("s6_pout",  32'(bus.Pout),  32'hD);
      check("s6_valid", 32'(bus.valid), 32'd1);

      // Randomized traffic against the model.
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         bit r, e, s, rdy;
         r   = ($urandom_range(0, 299) == 0);
         e   = ($urandom_range(0, 9) < 7);
         s   = ($urandom_range(0, 9) < 6);
         rdy = ($urandom_range(0, 3) == 0);
         cycle(r, e, s, rdy);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "timeout");
   end

endmodule : tb_sipo_frame_ctrl
